// File: rtl/ring_counter_pkg.sv
// Shared types, widths and the rotate helper for the ring-counter checker.
package ring_counter_pkg;

    localparam int unsigned RING_WIDTH  = 8;
    localparam int unsigned INDEX_WIDTH = 3;

    typedef enum logic [1:0] {
        StIdle,
        StAcquire,
        StLocked,
        StFault
    } ring_state_e;

    // Expected next word of a ring counter advancing one step in the given direction.
    function automatic logic [RING_WIDTH-1:0] rotate_next(
        input logic [RING_WIDTH-1:0] word,
        input logic                  left
    );
        if (left) begin
            return {word[RING_WIDTH-2:0], word[RING_WIDTH-1]};
        end
        return {word[0], word[RING_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/ring_onehot_encoder.sv
// Combinational 8-to-3 one-hot encoder with a legality flag (exactly one bit set).
module ring_onehot_encoder
    import ring_counter_pkg::*;
(
    input  logic [RING_WIDTH-1:0]  word_i,
    output logic [INDEX_WIDTH-1:0] index_o,
    output logic                   legal_o
);

    // Power-of-two test for legality; OR of set-bit positions for the index.
    always_comb begin
        index_o = '0;
        legal_o = (word_i != '0) && ((word_i & (word_i - 1'b1)) == '0);
        for (int i = 0; i < RING_WIDTH; i++) begin
            if (word_i[i]) begin
                index_o = index_o | INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/ring_counter_checker_8_bit.sv
// Observes an 8-bit one-hot ring counter, locks after LOCK_COUNT consecutive legal
// advances and flags violations once locked.
// Optional feature: define RING_CHECKER_ERR_COUNT_EN to add the saturating
// Error_Count_Out port and its counter.
module ring_counter_checker_8_bit
    import ring_counter_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 4,
    parameter bit          ROTATE_LEFT = 1'b1
) (
    input  logic                   Clk_In,
    input  logic                   Resetb_In,
    input  logic [RING_WIDTH-1:0]  Count_In,
    input  logic                   Advance_In,
    output logic [INDEX_WIDTH-1:0] Index_Out,
    output logic                   Index_Valid_Out,
    output logic                   Locked_Out,
    output logic                   Error_Out
`ifdef RING_CHECKER_ERR_COUNT_EN
    ,
    output logic [7:0]             Error_Count_Out
`endif
);

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

    ring_state_e           state_q;
    logic [RING_WIDTH-1:0] prev_q;
    logic [3:0]            good_q;

    logic [INDEX_WIDTH-1:0] enc_index;
    logic                   enc_legal;
    logic                   adv_ok;
    logic                   hold_ok;
    logic                   violation;
    logic [3:0]             good_inc;

    ring_onehot_encoder u_encoder (
        .word_i  (Count_In),
        .index_o (enc_index),
        .legal_o (enc_legal)
    );

    // Classify the current word against the previous sample.
    always_comb begin
        adv_ok    = enc_legal && Advance_In && (Count_In == rotate_next(prev_q, ROTATE_LEFT));
        hold_ok   = enc_legal && !Advance_In && (Count_In == prev_q);
        violation = (state_q == StLocked) && !(adv_ok || hold_ok);
        good_inc  = good_q + 4'd1;
    end

    // Checker FSM with registered outputs.
    always_ff @(posedge Clk_In or negedge Resetb_In) begin
        if (!Resetb_In) begin
            state_q         <= StIdle;
            prev_q          <= '0;
            good_q          <= '0;
            Index_Out       <= '0;
            Index_Valid_Out <= 1'b0;
            Locked_Out      <= 1'b0;
            Error_Out       <= 1'b0;
        end else begin
            prev_q          <= Count_In;
            Index_Valid_Out <= enc_legal;
            Error_Out       <= violation;
            if (enc_legal) begin
                Index_Out <= enc_index;
            end
            unique case (state_q)
                StIdle: begin
                    good_q     <= '0;
                    Locked_Out <= 1'b0;
                    if (enc_legal) begin
                        state_q <= StAcquire;
                    end
                end
                StAcquire: begin
                    Locked_Out <= 1'b0;
                    if (!enc_legal) begin
                        state_q <= StIdle;
                        good_q  <= '0;
                    end else if (adv_ok) begin
                        if (good_inc >= LockCnt) begin
                            state_q    <= StLocked;
                            Locked_Out <= 1'b1;
                            good_q     <= '0;
                        end else begin
                            good_q <= good_inc;
                        end
                    end else if (!hold_ok) begin
                        good_q <= '0;
                    end
                end
                StLocked: begin
                    if (violation) begin
                        state_q    <= StFault;
                        Locked_Out <= 1'b0;
                    end else begin
                        Locked_Out <= 1'b1;
                    end
                end
                StFault: begin
                    // Single recovery cycle; whatever is seen here is not a new violation.
                    good_q     <= '0;
                    Locked_Out <= 1'b0;
                    state_q    <= enc_legal ? StAcquire : StIdle;
                end
                default: begin
                    state_q    <= StIdle;
                    good_q     <= '0;
                    Locked_Out <= 1'b0;
                end
            endcase
        end
    end

`ifdef RING_CHECKER_ERR_COUNT_EN
    // Saturating count of violations, stepped on the same edge that raises Error_Out.
    always_ff @(posedge Clk_In or negedge Resetb_In) begin
        if (!Resetb_In) begin
            Error_Count_Out <= 8'h00;
        end else if (violation && (Error_Count_Out != 8'hFF)) begin
            Error_Count_Out <= Error_Count_Out + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ring_counter_checker_8_bit.sv
// Directed bench for ring_counter_checker_8_bit (LOCK_COUNT=4, rotate-left).
module tb_ring_counter_checker_8_bit;

    logic       clk;
    logic       resetb;
    logic [7:0] count;
    logic       advance;
    logic [2:0] index;
    logic       index_valid;
    logic       locked;
    logic       error;
`ifdef RING_CHECKER_ERR_COUNT_EN
    logic [7:0] err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ring_counter_checker_8_bit #(
        .LOCK_COUNT  (4),
        .ROTATE_LEFT (1'b1)
    ) dut (
        .Clk_In          (clk),
        .Resetb_In       (resetb),
        .Count_In        (count),
        .Advance_In      (advance),
        .Index_Out       (index),
        .Index_Valid_Out (index_valid),
        .Locked_Out      (locked),
        .Error_Out       (error)
`ifdef RING_CHECKER_ERR_COUNT_EN
        ,
        .Error_Count_Out (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one word on the falling edge, then settle just after the rising edge.
    task automatic step(input logic [7:0] w, input logic adv);
        @(negedge clk);
        count   = w;
        advance = adv;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [2:0] idx, input logic vld,
                             input logic lck, input logic err);
        check_eq({tag, ".idx"}, 32'(index), 32'(idx));
        check_eq({tag, ".vld"}, 32'(index_valid), 32'(vld));
        check_eq({tag, ".lck"}, 32'(locked), 32'(lck));
        check_eq({tag, ".err"}, 32'(error), 32'(err));
    endtask

    initial begin
        resetb  = 1'b0;
        count   = 8'h00;
        advance = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
`ifdef RING_CHECKER_ERR_COUNT_EN
        check_eq("reset.cnt", 32'(err_cnt), 32'h0);
`endif
        @(negedge clk);
        resetb = 1'b1;

        // Acquire and lock on 01..10.
        step(8'h01, 1'b1); check_out("acq01", 3'd0, 1'b1, 1'b0, 1'b0);
        step(8'h02, 1'b1); check_out("acq02", 3'd1, 1'b1, 1'b0, 1'b0);
        step(8'h04, 1'b1);
        step(8'h08, 1'b1); check_out("acq08", 3'd3, 1'b1, 1'b0, 1'b0);
        step(8'h10, 1'b1); check_out("lock10", 3'd4, 1'b1, 1'b1, 1'b0);

        // Wrap while locked.
        step(8'h20, 1'b1);
        step(8'h40, 1'b1); check_out("wrap40", 3'd6, 1'b1, 1'b1, 1'b0);
        step(8'h80, 1'b1); check_out("wrap80", 3'd7, 1'b1, 1'b1, 1'b0);
        step(8'h01, 1'b1); check_out("wrap01", 3'd0, 1'b1, 1'b1, 1'b0);

        // Hold at 08 for five cycles, then a stalled advance.
        step(8'h02, 1'b1);
        step(8'h04, 1'b1);
        step(8'h08, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(8'h08, 1'b0); check_out("hold08", 3'd3, 1'b1, 1'b1, 1'b0);
        end
        step(8'h08, 1'b1); check_out("stall", 3'd3, 1'b1, 1'b0, 1'b1);
`ifdef RING_CHECKER_ERR_COUNT_EN
        check_eq("stall.cnt", 32'(err_cnt), 32'h1);
`endif
        step(8'h10, 1'b1); check_out("fault1", 3'd4, 1'b1, 1'b0, 1'b0);

        // Re-lock after four more advances.
        step(8'h20, 1'b1);
        step(8'h40, 1'b1);
        step(8'h80, 1'b1); check_out("relock80", 3'd7, 1'b1, 1'b0, 1'b0);
        step(8'h01, 1'b1); check_out("relock01", 3'd0, 1'b1, 1'b1, 1'b0);

        // Jump 04 -> 10 while locked.
        step(8'h02, 1'b1);
        step(8'h04, 1'b1);
        step(8'h10, 1'b1); check_out("jump", 3'd4, 1'b1, 1'b0, 1'b1);
`ifdef RING_CHECKER_ERR_COUNT_EN
        check_eq("jump.cnt", 32'(err_cnt), 32'h2);
`endif
        step(8'h20, 1'b1); check_out("jump.pulse", 3'd5, 1'b1, 1'b0, 1'b0);
        step(8'h40, 1'b1);
        step(8'h80, 1'b1);
        step(8'h01, 1'b1); check_out("jumpacq01", 3'd0, 1'b1, 1'b0, 1'b0);
        step(8'h02, 1'b1); check_out("jumplock", 3'd1, 1'b1, 1'b1, 1'b0);

        // Illegal multi-bit word while locked.
        step(8'h03, 1'b1); check_out("multi", 3'd1, 1'b0, 1'b0, 1'b1);
        step(8'h03, 1'b1); check_out("multi.f", 3'd1, 1'b0, 1'b0, 1'b0);
        step(8'h03, 1'b0); check_out("multi.idle", 3'd1, 1'b0, 1'b0, 1'b0);
        step(8'h04, 1'b1); check_out("idle2acq", 3'd2, 1'b1, 1'b0, 1'b0);

        // Mismatch during acquire: no error, run restarts.
        step(8'h40, 1'b1); check_out("acqmis", 3'd6, 1'b1, 1'b0, 1'b0);
        step(8'h80, 1'b1);
        step(8'h01, 1'b1);
        step(8'h02, 1'b1); check_out("acqmis02", 3'd1, 1'b1, 1'b0, 1'b0);
        step(8'h04, 1'b1); check_out("acqmislock", 3'd2, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset between edges while locked.
        #2;
        resetb = 1'b0;
        #1;
        check_out("async", 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resetb = 1'b1;
        step(8'h08, 1'b1); check_out("postrst", 3'd3, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ring_counter_checker_8_bit.md
RING_COUNTER_CHECKER_8_BIT -- requirements
Module: ring_counter_checker_8_bit

Interface
REQ-001 Parameter LOCK_COUNT, default 4, meaning: number of consecutive legal advances needed to enter LOCKED (range 1..15).
REQ-002 Parameter ROTATE_LEFT, default 1, meaning: 1 = legal advance is rotate-left (8'h80 -> 8'h01 wraps), 0 = rotate-right (8'h01 -> 8'h80 wraps).
REQ-003 Clk_In  input  1  single clock; all state updates on rising edge.
REQ-004 Resetb_In  input  1  asynchronous, active-low reset.
REQ-005 Count_In  input  8  one-hot ring-counter word under observation.
REQ-006 Advance_In  input  1  high = Count_In is expected to have advanced this cycle; low = Count_In is expected to hold.
REQ-007 Index_Out  output  3  binary position of the set bit of the last sampled legal word.
REQ-008 Index_Valid_Out  output  1  Index_Out reflects a legal one-hot word.
REQ-009 Locked_Out  output  1  checker is in LOCKED state.
REQ-010 Error_Out  output  1  one-cycle pulse per detected violation.
REQ-011 Error_Count_Out  output  8  saturating violation count (present only per REQ-027).

Function
REQ-012 Every clock, Count_In is sampled into a previous-word register; all outputs are registered, latency one cycle from sample.
REQ-013 Word is legal one-hot iff exactly one bit set; 8'h00 and multi-bit words are illegal.
REQ-014 FSM states: IDLE, ACQUIRE, LOCKED, FAULT.
REQ-015 IDLE: on legal word -> ACQUIRE with good-run counter = 0; on illegal word stay IDLE, no Error_Out.
REQ-016 ACQUIRE: Advance_In high and word == expected rotation of previous -> good-run +1; when good-run reaches LOCK_COUNT -> LOCKED; Advance_In low and word == previous -> hold, no change.
REQ-017 ACQUIRE: any mismatch or illegal word -> good-run = 0, stay ACQUIRE if word legal else IDLE; no Error_Out (not yet locked).
REQ-018 LOCKED: legal advance or legal hold keeps LOCKED; any mismatch, illegal word, advance without change, or change without Advance_In -> FAULT and Error_Out pulses for one cycle.
REQ-019 FAULT: one-cycle state; next cycle -> ACQUIRE if current word legal, else IDLE; violations seen in FAULT are not counted again.
REQ-020 Index_Out/Index_Valid_Out update on every legal word in any state; on illegal word Index_Valid_Out = 0 and Index_Out holds.
REQ-021 Wrap-around (8'h80 -> 8'h01 for ROTATE_LEFT=1, 8'h01 -> 8'h80 for 0) is a legal advance.
REQ-022 Advance_In high with Count_In unchanged is a violation in LOCKED (stalled counter).

Reset
REQ-023 Resetb_In low asynchronously forces: state IDLE, good-run 0, previous word 8'h00, Index_Out 3'd0, Index_Valid_Out 0, Locked_Out 0, Error_Out 0, Error_Count_Out 8'h00.
REQ-024 Reset release is synchronous to Clk_In; first sample taken on first rising edge after Resetb_In high.
REQ-025 Reset asserted mid-LOCKED abandons lock with no Error_Out pulse.

Configuration
REQ-026 Macro RING_CHECKER_ERR_COUNT_EN selects the error counter.
REQ-027 Defined: Error_Count_Out present, increments on each Error_Out pulse, saturates at 8'hFF. Undefined: port absent, no counter logic.

Structure
REQ-028 Package ring_counter_pkg holds the state enum, RING_WIDTH = 8, INDEX_WIDTH = 3, and the rotate helper function.
REQ-029 Sub-module ring_onehot_encoder: combinational 8-to-3 encoder plus one-hot legality flag, instantiated once.

Verification
REQ-030 Reset, then 8'h01,02,04,08,10 with Advance_In=1 (LOCK_COUNT=4) -> Locked_Out=1 one cycle after 8'h10 sampled, Index_Out=3'd4.
REQ-031 Locked, sequence ...8'h40,8'h80,8'h01 -> Locked_Out stays 1, Index_Out 6,7,0, no Error_Out.
REQ-032 Locked, Count_In jumps 8'h04 -> 8'h10 -> Error_Out single pulse, FSM FAULT then ACQUIRE, Error_Count_Out = 1 (macro defined).
REQ-033 Locked, Count_In = 8'h03 -> Error_Out pulse, Index_Valid_Out = 0, Index_Out holds, state returns IDLE.
REQ-034 Locked, Advance_In=0 for 5 cycles with Count_In held at 8'h08 -> stays LOCKED, no error; then Advance_In=1 with 8'h08 unchanged -> Error_Out pulse.
REQ-035 Resetb_In pulsed low between clock edges while LOCKED -> all outputs at reset values immediately, no Error_Out.
